// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared defaults and saturation bounds for accumulator_multi
// Saturation bounds are returned wide; callers cast down to their ACC_W.
package acc_pkg;

  localparam int DEF_IN_W    = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_CH      = 4;
  localparam int DEF_WIN_LEN = 9;
  localparam int MAX_W       = 64;

  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/acc_lane.sv
// rtl/acc_lane.sv - one channel: accumulator register, adder, optional clamp and sticky flag
// Clamp and sticky flag exist only with ACCUMULATOR_MULTI_SAT_EN defined.
module acc_lane
  import acc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  sample,
  input  logic             add,
  input  logic             clear,
`ifdef ACCUMULATOR_MULTI_SAT_EN
  output logic             sat,
`endif
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ext;

  assign ext = ACC_W'($signed(sample));

`ifdef ACCUMULATOR_MULTI_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] wide;
  logic           ovf;
  logic           sticky;

  // One guard bit: overflow when the guard and the result MSB disagree.
  assign wide = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];
  assign sum  = ovf ? (wide[ACC_W] ? SAT_MIN : SAT_MAX) : wide[ACC_W-1:0];
  assign sat  = sticky | ovf;
`else
  assign sum = acc + ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
`ifdef ACCUMULATOR_MULTI_SAT_EN
      sticky <= 1'b0;
`endif
    end else if (clear) begin
      acc <= '0;
`ifdef ACCUMULATOR_MULTI_SAT_EN
      sticky <= 1'b0;
`endif
    end else if (add) begin
      acc <= sum;
`ifdef ACCUMULATOR_MULTI_SAT_EN
      sticky <= sat;
`endif
    end
  end

endmodule

// File: rtl/accumulator_multi.sv
// rtl/accumulator_multi.sv - multi-channel windowed accumulator with one-deep result slot
// Optional saturation and out_sat port with ACCUMULATOR_MULTI_SAT_EN defined.
module accumulator_multi
  import acc_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int CH      = DEF_CH,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*IN_W-1:0]  in_data,
  input  logic                in_clear,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef ACCUMULATOR_MULTI_SAT_EN
  output logic [CH-1:0]       out_sat,
`endif
  output logic [CH*ACC_W-1:0] out_data
);

  localparam int CW = $clog2(WIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  logic [CW-1:0]       count;
  logic                last;
  logic                accept;
  logic                done;
  logic                lane_clear;
  logic [CH*ACC_W-1:0] lane_sum;
`ifdef ACCUMULATOR_MULTI_SAT_EN
  logic [CH-1:0]       lane_sat;
`endif

  assign last       = (count == LAST);
  // Only the window-completing beat can be stalled by a full slot.
  assign in_ready   = !last || !out_valid || out_ready;
  assign accept     = in_valid && in_ready && !in_clear;
  assign done       = accept && last;
  assign lane_clear = in_clear || done;

  for (genvar g = 0; g < CH; g++) begin : g_lane
    acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .sample (in_data[g*IN_W +: IN_W]),
      .add    (accept),
      .clear  (lane_clear),
`ifdef ACCUMULATOR_MULTI_SAT_EN
      .sat    (lane_sat[g]),
`endif
      .sum    (lane_sum[g*ACC_W +: ACC_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef ACCUMULATOR_MULTI_SAT_EN
      out_sat   <= '0;
`endif
    end else begin
      if (in_clear)
        count <= '0;
      else if (accept)
        count <= last ? '0 : count + CW'(1);

      if (done) begin
        out_valid <= 1'b1;
        out_data  <= lane_sum;
`ifdef ACCUMULATOR_MULTI_SAT_EN
        out_sat   <= lane_sat;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_multi.sv
// tb/tb_accumulator_multi.sv - randomized and directed checks against a behavioural window model
// Expectations depend on whether ACCUMULATOR_MULTI_SAT_EN is defined.
module tb_accumulator_multi;

  localparam int IN_W  = 8;
  localparam int ACC_W = 16;
  localparam int CH    = 4;
  localparam int WIN   = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid = 1'b0;
  logic                in_clear = 1'b0;
  logic                out_ready = 1'b0;
  logic [CH*IN_W-1:0]  in_data = '0;
  logic                in_ready;
  logic                out_valid;
  logic [CH*ACC_W-1:0] out_data;

  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_in_ready;
  logic       s_out_valid;
  logic [9:0] s_out_data;

`ifdef ACCUMULATOR_MULTI_SAT_EN
  logic [CH-1:0] out_sat;
  logic [0:0]    s_out_sat;
`endif

  accumulator_multi u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ACCUMULATOR_MULTI_SAT_EN
    .out_sat   (out_sat),
`endif
    .out_data  (out_data)
  );

  accumulator_multi #(.IN_W(8), .ACC_W(10), .CH(1), .WIN_LEN(9)) u_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_data),
    .in_clear  (1'b0),
    .out_valid (s_out_valid),
    .out_ready (1'b1),
`ifdef ACCUMULATOR_MULTI_SAT_EN
    .out_sat   (s_out_sat),
`endif
    .out_data  (s_out_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: running integer sums per channel, a beat count and a one-entry result slot.
  int               m_acc [CH];
  int               m_cnt;
  bit               m_ov;
  bit               m_rdy;
  bit               m_done;
  logic [ACC_W-1:0] m_out [CH];

  function automatic bit model_ready();
    return (m_cnt != WIN - 1) || !m_ov || out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0;
        m_out[c] = '0;
      end
      m_cnt = 0;
      m_ov  = 0;
    end else begin
      m_rdy  = model_ready();
      m_done = 0;
      if (in_clear) begin
        for (int c = 0; c < CH; c++) m_acc[c] = 0;
        m_cnt = 0;
      end else if (in_valid && m_rdy) begin
        for (int c = 0; c < CH; c++)
          m_acc[c] += int'($signed(in_data[c*IN_W +: IN_W]));
        if (m_cnt == WIN - 1) begin
          m_done = 1;
          for (int c = 0; c < CH; c++) begin
            m_out[c] = ACC_W'(m_acc[c]);
            m_acc[c] = 0;
          end
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (m_done) m_ov = 1;
      else if (m_ov && out_ready) m_ov = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, model_ready());
      chk("out_valid", out_valid, m_ov);
      if (m_ov && out_valid) begin
        for (int c = 0; c < CH; c++)
          chk("out_data", out_data[c*ACC_W +: ACC_W], m_out[c]);
`ifdef ACCUMULATOR_MULTI_SAT_EN
        chk("out_sat", out_sat, 0);
`endif
      end
    end
  end

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait, bounded, until it is accepted; in_valid stays high.
  task automatic send(input logic [31:0] d);
    bit r;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      r = in_ready;
      cyc();
      n++;
    end while (!r && n < 50);
    if (!r) begin
      failures++;
      $display("FAIL send_timeout actual=stalled required=accepted at %0t", $time);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    #30 rst = 1'b0;
    cyc();

    // Nine beats of +1 on every channel.
    out_ready = 1'b1;
    for (int i = 0; i < WIN; i++) send(pack(1, 1, 1, 1));
    in_valid = 1'b0;
    chk("ones_valid", out_valid, 1);
    for (int c = 0; c < CH; c++) chk("ones_data", out_data[c*ACC_W +: ACC_W], 9);
    cyc();
    chk("ones_drained", out_valid, 0);

    // Mixed signs.
    for (int i = 0; i < WIN; i++) send(pack(-3, 5, 0, 1));
    in_valid = 1'b0;
    chk("mix_valid", out_valid, 1);
    chk("mix_ch0", out_data[15:0], 16'hFFE5);
    chk("mix_ch1", out_data[31:16], 45);
    chk("mix_ch2", out_data[47:32], 0);
    chk("mix_ch3", out_data[63:48], 9);
    chk("model_ch0", m_out[0], 16'hFFE5);
    cyc();

    // Back-pressure: second window's final beat must stall behind the held result.
    out_ready = 1'b0;
    for (int i = 0; i < 2*WIN - 1; i++) send(i < WIN ? pack(1, 1, 1, 1) : pack(2, 2, 2, 2));
    chk("bp_ready_low", in_ready, 0);
    chk("bp_held_valid", out_valid, 1);
    chk("bp_held_data", out_data[15:0], 9);
    repeat (3) cyc();
    chk("bp_still_low", in_ready, 0);
    chk("bp_still_held", out_data[31:16], 9);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_high", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", out_data[15:0], 18);
    chk("bp_second_data3", out_data[63:48], 18);
    cyc();
    chk("bp_drained", out_valid, 0);

    // Clear with a beat offered: beat dropped, fresh window of nine.
    for (int i = 0; i < 4; i++) send(pack(1, 1, 1, 1));
    in_clear = 1'b1;
    in_valid = 1'b1;
    cyc();
    in_clear = 1'b0;
    for (int i = 0; i < WIN - 1; i++) send(pack(1, 1, 1, 1));
    chk("clr_not_done", out_valid, 0);
    send(pack(1, 1, 1, 1));
    in_valid = 1'b0;
    chk("clr_done", out_valid, 1);
    chk("clr_data", out_data[15:0], 9);
    cyc();

    // Narrow accumulator: 9 x +127 into 10 bits.
    s_valid = 1'b1;
    s_data  = 8'd127;
    repeat (WIN) cyc();
    s_valid = 1'b0;
    chk("small_valid", s_out_valid, 1);
`ifdef ACCUMULATOR_MULTI_SAT_EN
    chk("small_sat_data", s_out_data, 511);
    chk("small_sat_flag", s_out_sat, 1);
`else
    chk("small_wrap_data", s_out_data, 119);
`endif
    cyc();

    // Asynchronous reset mid-window.
    for (int i = 0; i < 4; i++) send(pack(3, 3, 3, 3));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_mid_ready", in_ready, 1);
    chk("arst_mid_valid", out_valid, 0);
    #2 rst = 1'b0;
    cyc();

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    for (int i = 0; i < WIN; i++) send(pack(4, 4, 4, 4));
    in_valid = 1'b0;
    chk("arst_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_full_valid", out_valid, 0);
    chk("arst_full_data", out_data, 0);
    chk("arst_full_ready", in_ready, 1);
`ifdef ACCUMULATOR_MULTI_SAT_EN
    chk("arst_full_sat", out_sat, 0);
`endif
    #2 rst = 1'b0;
    cyc();
    // Partial window discarded: a fresh 9-beat window of +1 must sum to exactly 9.
    out_ready = 1'b1;
    for (int i = 0; i < WIN; i++) send(pack(1, 1, 1, 1));
    in_valid = 1'b0;
    chk("post_rst_data", out_data[47:32], 9);
    cyc();

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_clear  = ($urandom % 40) == 0;
      in_data   = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    in_clear = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
